spsram_arbiter: RTL and testbench

//  - Shares one single-port SRAM (sync read, 1-cycle latency, active-high cen/wen/oen) between two requesters, A and B.
//  - Uses round-robin arbitration with optional burst lock; one SRAM access per cycle.
//  - Returns read data with a per-requester rvalid pulse; sits between bus-side masters and the SRAM macro.

---
 rtl/spsram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_spsram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spsram_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port sync SRAM between requesters A and B.
// Define SPSRAM_ARB_RDATA_REG_EN to register read data (2-edge read latency, rdata holds between pulses).
module spsram_arbiter #(
    parameter int unsigned BW_DATA   = 32,
    parameter int unsigned BW_ADDR   = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,

    input  logic               i_a_req,
    output logic               o_a_gnt,
    input  logic               i_a_wen,
    input  logic               i_a_lock,
    input  logic [BW_ADDR-1:0] i_a_addr,
    input  logic [BW_DATA-1:0] i_a_wdata,
    output logic               o_a_rvalid,
    output logic [BW_DATA-1:0] o_a_rdata,

    input  logic               i_b_req,
    output logic               o_b_gnt,
    input  logic               i_b_wen,
    input  logic               i_b_lock,
    input  logic [BW_ADDR-1:0] i_b_addr,
    input  logic [BW_DATA-1:0] i_b_wdata,
    output logic               o_b_rvalid,
    output logic [BW_DATA-1:0] o_b_rdata,

    output logic               o_sram_cen,
    output logic               o_sram_wen,
    output logic               o_sram_oen,
    output logic [BW_ADDR-1:0] o_sram_addr,
    output logic [BW_DATA-1:0] o_sram_data,
    input  logic [BW_DATA-1:0] i_sram_data
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

    state_e        state_q;
    logic          rr_q;      // 0: A wins a tie, 1: B wins a tie
    logic [CW-1:0] cnt_q;

    logic hold_a;
    logic hold_b;
    logic ptr_b;
    logic gnt_a;
    logic gnt_b;
    logic rd_gnt_a;
    logic rd_gnt_b;

    // Arbitration: a live lock owner wins outright; otherwise IDLE rules apply, and on the
    // exit cycle from a burst the pointer is forced to the other side so nobody starves.
    always_comb begin
        hold_a = (state_q == StOwnA) && i_a_req && i_a_lock && (cnt_q < CW'(MAX_BURST));
        hold_b = (state_q == StOwnB) && i_b_req && i_b_lock && (cnt_q < CW'(MAX_BURST));
        ptr_b  = (state_q == StOwnA) ? 1'b1 :
                 (state_q == StOwnB) ? 1'b0 : rr_q;
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        if (i_rstn) begin
            if (hold_a) begin
                gnt_a = 1'b1;
            end else if (hold_b) begin
                gnt_b = 1'b1;
            end else if (i_a_req && (!i_b_req || !ptr_b)) begin
                gnt_a = 1'b1;
            end else if (i_b_req) begin
                gnt_b = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (gnt_a) begin
            rr_q <= 1'b1;
            if (hold_a) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (i_a_lock) begin
                state_q <= StOwnA;
                cnt_q   <= CW'(1);
            end else begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end
        end else if (gnt_b) begin
            rr_q <= 1'b0;
            if (hold_b) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (i_b_lock) begin
                state_q <= StOwnB;
                cnt_q   <= CW'(1);
            end else begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end
        end else begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end
    end

    assign o_a_gnt = gnt_a;
    assign o_b_gnt = gnt_b;

    always_comb begin
        o_sram_cen  = gnt_a | gnt_b;
        o_sram_wen  = 1'b0;
        o_sram_addr = '0;
        o_sram_data = '0;
        if (gnt_a) begin
            o_sram_wen  = i_a_wen;
            o_sram_addr = i_a_addr;
            o_sram_data = i_a_wdata;
        end else if (gnt_b) begin
            o_sram_wen  = i_b_wen;
            o_sram_addr = i_b_addr;
            o_sram_data = i_b_wdata;
        end
        o_sram_oen = o_sram_cen & ~o_sram_wen;
    end

    assign rd_gnt_a = gnt_a & ~i_a_wen;
    assign rd_gnt_b = gnt_b & ~i_b_wen;

`ifdef SPSRAM_ARB_RDATA_REG_EN
    logic               pend_a_q;
    logic               pend_b_q;
    logic               rvalid_a_q;
    logic               rvalid_b_q;
    logic [BW_DATA-1:0] rdata_a_q;
    logic [BW_DATA-1:0] rdata_b_q;

    // SRAM data is valid during the cycle after the grant edge; capture it on the next edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            pend_a_q   <= rd_gnt_a;
            pend_b_q   <= rd_gnt_b;
            rvalid_a_q <= pend_a_q;
            rvalid_b_q <= pend_b_q;
            if (pend_a_q) begin
                rdata_a_q <= i_sram_data;
            end
            if (pend_b_q) begin
                rdata_b_q <= i_sram_data;
            end
        end
    end

    assign o_a_rvalid = rvalid_a_q;
    assign o_b_rvalid = rvalid_b_q;
    assign o_a_rdata  = rdata_a_q;
    assign o_b_rdata  = rdata_b_q;
`else
    logic rvalid_a_q;
    logic rvalid_b_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            rvalid_a_q <= rd_gnt_a;
            rvalid_b_q <= rd_gnt_b;
        end
    end

    assign o_a_rvalid = rvalid_a_q;
    assign o_b_rvalid = rvalid_b_q;
    assign o_a_rdata  = rvalid_a_q ? i_sram_data : '0;
    assign o_b_rdata  = rvalid_b_q ? i_sram_data : '0;
`endif

endmodule

// File: tb/tb_spsram_arbiter.sv
// Directed, table-driven bench for spsram_arbiter with a behavioural sync SRAM.
module tb_spsram_arbiter;

`ifdef SPSRAM_ARB_RDATA_REG_EN
    localparam int LAT   = 2;
    localparam bit RDREG = 1'b1;
`else
    localparam int LAT   = 1;
    localparam bit RDREG = 1'b0;
`endif

    typedef struct packed {
        logic        req;
        logic        wen;
        logic        lock;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        req_t        a;
        req_t        b;
        logic        ga;
        logic        gb;
        logic [31:0] rd;
    } vec_t;

    logic        i_clk, i_rstn;
    logic        i_a_req, i_a_wen, i_a_lock, o_a_gnt, o_a_rvalid;
    logic [3:0]  i_a_addr;
    logic [31:0] i_a_wdata, o_a_rdata;
    logic        i_b_req, i_b_wen, i_b_lock, o_b_gnt, o_b_rvalid;
    logic [3:0]  i_b_addr;
    logic [31:0] i_b_wdata, o_b_rdata;
    logic        o_sram_cen, o_sram_wen, o_sram_oen;
    logic [3:0]  o_sram_addr;
    logic [31:0] o_sram_data, i_sram_data;

    spsram_arbiter #(
        .BW_DATA  (32),
        .BW_ADDR  (4),
        .MAX_BURST(4)
    ) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_a_req    (i_a_req),
        .o_a_gnt    (o_a_gnt),
        .i_a_wen    (i_a_wen),
        .i_a_lock   (i_a_lock),
        .i_a_addr   (i_a_addr),
        .i_a_wdata  (i_a_wdata),
        .o_a_rvalid (o_a_rvalid),
        .o_a_rdata  (o_a_rdata),
        .i_b_req    (i_b_req),
        .o_b_gnt    (o_b_gnt),
        .i_b_wen    (i_b_wen),
        .i_b_lock   (i_b_lock),
        .i_b_addr   (i_b_addr),
        .i_b_wdata  (i_b_wdata),
        .o_b_rvalid (o_b_rvalid),
        .o_b_rdata  (o_b_rdata),
        .o_sram_cen (o_sram_cen),
        .o_sram_wen (o_sram_wen),
        .o_sram_oen (o_sram_oen),
        .o_sram_addr(o_sram_addr),
        .o_sram_data(o_sram_data),
        .i_sram_data(i_sram_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural single-port SRAM, 1-cycle read latency
    logic [31:0] mem [16];
    logic [31:0] sram_q;
    always @(posedge i_clk) begin
        if (o_sram_cen) begin
            if (o_sram_wen) mem[o_sram_addr] <= o_sram_data;
            else            sram_q <= mem[o_sram_addr];
        end
    end
    assign i_sram_data = sram_q;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[$];

    function automatic req_t rd(input logic [3:0] addr, input logic lock);
        req_t r;
        r = '0;
        r.req = 1'b1; r.lock = lock; r.addr = addr;
        return r;
    endfunction

    function automatic req_t wr(input logic [3:0] addr, input logic [31:0] data);
        req_t r;
        r = '0;
        r.req = 1'b1; r.wen = 1'b1; r.addr = addr; r.wdata = data;
        return r;
    endfunction

    function automatic req_t nr();
        return '0;
    endfunction

    task automatic add(input req_t a, input req_t b, input logic ga, input logic gb,
                       input logic [31:0] rdat);
        vec_t v;
        v.a = a; v.b = b; v.ga = ga; v.gb = gb; v.rd = rdat;
        vecs.push_back(v);
    endtask

    task automatic apply(input req_t a, input req_t b);
        i_a_req = a.req; i_a_wen = a.wen; i_a_lock = a.lock; i_a_addr = a.addr;
        i_a_wdata = a.wdata;
        i_b_req = b.req; i_b_wen = b.wen; i_b_lock = b.lock; i_b_addr = b.addr;
        i_b_wdata = b.wdata;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, required %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all_zero(input int idx);
        chk("rst_gnt_a", idx, 32'(o_a_gnt), 32'd0);
        chk("rst_gnt_b", idx, 32'(o_b_gnt), 32'd0);
        chk("rst_cen", idx, 32'(o_sram_cen), 32'd0);
        chk("rst_wen", idx, 32'(o_sram_wen), 32'd0);
        chk("rst_oen", idx, 32'(o_sram_oen), 32'd0);
        chk("rst_addr", idx, 32'(o_sram_addr), 32'd0);
        chk("rst_data", idx, o_sram_data, 32'd0);
        chk("rst_rvalid_a", idx, 32'(o_a_rvalid), 32'd0);
        chk("rst_rvalid_b", idx, 32'(o_b_rvalid), 32'd0);
        chk("rst_rdata_a", idx, o_a_rdata, 32'd0);
        chk("rst_rdata_b", idx, o_b_rdata, 32'd0);
    endtask

    logic        pv_a [2];
    logic        pv_b [2];
    logic [31:0] pd_a [2];
    logic [31:0] pd_b [2];
    logic [31:0] last_a, last_b;

    initial begin
        vec_t        v;
        req_t        s;
        logic        ev;
        logic [31:0] ed;

        for (int k = 0; k < 16; k++) mem[k] = 32'd0;
        sram_q = 32'd0;
        for (int k = 0; k < 2; k++) begin
            pv_a[k] = 1'b0; pv_b[k] = 1'b0; pd_a[k] = 32'd0; pd_b[k] = 32'd0;
        end
        last_a = 32'd0;
        last_b = 32'd0;

        // {A, B, expected gnt A, expected gnt B, expected read data of the granted read}
        add(nr(),                 nr(),                 0, 0, 32'h0);
        add(wr(3, 32'hDEADBEEF),  nr(),                 1, 0, 32'h0);
        add(rd(3, 0),             nr(),                 1, 0, 32'hDEADBEEF);
        add(wr(6, 32'h66666666),  wr(5, 32'h55555555),  0, 1, 32'h0);
        add(wr(6, 32'h66666666),  nr(),                 1, 0, 32'h0);
        add(rd(3, 0),             rd(5, 0),             0, 1, 32'h55555555);
        add(rd(3, 0),             rd(6, 0),             1, 0, 32'hDEADBEEF);
        add(rd(5, 0),             rd(6, 0),             0, 1, 32'h66666666);
        add(rd(5, 0),             rd(3, 0),             1, 0, 32'h55555555);
        add(rd(6, 0),             rd(3, 0),             0, 1, 32'hDEADBEEF);
        add(rd(6, 0),             nr(),                 1, 0, 32'h66666666);
        add(nr(),                 wr(7, 32'h77777777),  0, 1, 32'h0);
        add(nr(),                 rd(7, 0),             0, 1, 32'h77777777);
        add(nr(),                 nr(),                 0, 0, 32'h0);
        add(nr(),                 nr(),                 0, 0, 32'h0);
        // burst: A locked for 6 requests against a constant B request
        add(rd(3, 1),             rd(5, 0),             1, 0, 32'hDEADBEEF);
        add(rd(6, 1),             rd(5, 0),             1, 0, 32'h66666666);
        add(rd(5, 1),             rd(5, 0),             1, 0, 32'h55555555);
        add(rd(7, 1),             rd(5, 0),             1, 0, 32'h77777777);
        add(rd(3, 1),             rd(5, 0),             0, 1, 32'h55555555);
        add(rd(3, 1),             rd(7, 0),             1, 0, 32'hDEADBEEF);
        add(rd(6, 1),             rd(7, 0),             1, 0, 32'h66666666);
        add(nr(),                 rd(7, 0),             0, 1, 32'h77777777);
        add(nr(),                 nr(),                 0, 0, 32'h0);
        // lock drop after two grants
        add(rd(3, 1),             rd(5, 0),             1, 0, 32'hDEADBEEF);
        add(rd(6, 1),             rd(5, 0),             1, 0, 32'h66666666);
        add(rd(7, 0),             rd(5, 0),             0, 1, 32'h55555555);
        add(rd(7, 0),             nr(),                 1, 0, 32'h77777777);
        add(nr(),                 nr(),                 0, 0, 32'h0);
        add(nr(),                 nr(),                 0, 0, 32'h0);
        // B burst, released by req drop
        add(rd(5, 0),             rd(3, 1),             0, 1, 32'hDEADBEEF);
        add(rd(5, 0),             rd(6, 1),             0, 1, 32'h66666666);
        add(rd(5, 0),             nr(),                 1, 0, 32'h55555555);
        add(nr(),                 nr(),                 0, 0, 32'h0);

        apply(nr(), nr());
        i_rstn = 1'b0;
        @(negedge i_clk);
        chk_all_zero(0);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            apply(v.a, v.b);
            @(negedge i_clk);
            s = v.ga ? v.a : (v.gb ? v.b : nr());
            chk("gnt_a", i, 32'(o_a_gnt), 32'(v.ga));
            chk("gnt_b", i, 32'(o_b_gnt), 32'(v.gb));
            chk("cen", i, 32'(o_sram_cen), 32'(v.ga | v.gb));
            chk("wen", i, 32'(o_sram_wen), 32'(s.wen));
            chk("oen", i, 32'(o_sram_oen), 32'((v.ga | v.gb) & ~s.wen));
            chk("addr", i, 32'(o_sram_addr), 32'(s.addr));
            chk("wdata", i, o_sram_data, s.wdata);

            ev = pv_a[LAT-1];
            ed = ev ? pd_a[LAT-1] : (RDREG ? last_a : 32'd0);
            if (ev) last_a = pd_a[LAT-1];
            chk("rvalid_a", i, 32'(o_a_rvalid), 32'(ev));
            chk("rdata_a", i, o_a_rdata, ed);
            ev = pv_b[LAT-1];
            ed = ev ? pd_b[LAT-1] : (RDREG ? last_b : 32'd0);
            if (ev) last_b = pd_b[LAT-1];
            chk("rvalid_b", i, 32'(o_b_rvalid), 32'(ev));
            chk("rdata_b", i, o_b_rdata, ed);

            pv_a[1] = pv_a[0]; pd_a[1] = pd_a[0];
            pv_b[1] = pv_b[0]; pd_b[1] = pd_b[0];
            pv_a[0] = v.ga & ~v.a.wen; pd_a[0] = v.rd;
            pv_b[0] = v.gb & ~v.b.wen; pd_b[0] = v.rd;
            @(posedge i_clk);
            #1;
        end

        // Reset mid-burst with a read in flight: pointer was at B, must come back at A
        apply(rd(5, 1), rd(6, 1));
        @(negedge i_clk);
        chk("pre_rst_gnt_b", 100, 32'(o_b_gnt), 32'd1);
        @(posedge i_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        chk_all_zero(101);
        @(negedge i_clk);
        i_rstn = 1'b1;
        apply(rd(5, 0), rd(6, 0));
        #1;
        chk("post_rst_gnt_a", 102, 32'(o_a_gnt), 32'd1);
        chk("post_rst_gnt_b", 102, 32'(o_b_gnt), 32'd0);
        chk("dropped_rvalid_b", 102, 32'(o_b_rvalid), 32'd0);
        @(posedge i_clk);
        #1;
        apply(nr(), rd(6, 0));
        @(negedge i_clk);
        chk("post_rst_gnt_b2", 103, 32'(o_b_gnt), 32'd1);
        chk("post_rst_rvalid_a", 103, 32'(o_a_rvalid), 32'(LAT == 1));
        chk("post_rst_rdata_a", 103, o_a_rdata, (LAT == 1) ? 32'h55555555 : 32'd0);
        @(posedge i_clk);
        #1;
        apply(nr(), nr());
        @(negedge i_clk);
        chk("idle_cen", 104, 32'(o_sram_cen), 32'd0);
        chk("idle_oen", 104, 32'(o_sram_oen), 32'd0);
        chk("post_rst_rvalid_a2", 104, 32'(o_a_rvalid), 32'(LAT == 2));
        chk("post_rst_rdata_a2", 104, o_a_rdata, (LAT == 2) ? 32'h55555555 : 32'd0);
        chk("post_rst_rvalid_b", 104, 32'(o_b_rvalid), 32'(LAT == 1));
        chk("post_rst_rdata_b", 104, o_b_rdata, (LAT == 1) ? 32'h66666666 : 32'd0);
        @(negedge i_clk);
        chk("tail_rvalid_a", 105, 32'(o_a_rvalid), 32'd0);
        chk("tail_rdata_a", 105, o_a_rdata, RDREG ? 32'h55555555 : 32'd0);
        chk("tail_rvalid_b", 105, 32'(o_b_rvalid), 32'(LAT == 2));
        chk("tail_rdata_b", 105, o_b_rdata, (LAT == 2) ? 32'h66666666 : 32'd0);
        @(negedge i_clk);
        chk("hold_rvalid_b", 106, 32'(o_b_rvalid), 32'd0);
        chk("hold_rdata_b", 106, o_b_rdata, RDREG ? 32'h66666666 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
